cr_kme_stall_fifo_p: RTL and testbench

Parametrised synchronous FIFO for KME datapath channels. Owns its storage array and pointers; it does not wrap a generic FIFO.
Adds four things to the fixed 34-bit, 4-deep stall FIFO: a programmable stall threshold, a working stall override, a synchronous clear, and occupancy outputs.
Sits between a KME producer stage (valid/stall) and a consumer stage (valid/ack).

---
 rtl/cr_kme_stall_fifo_p.sv | 172 +++++++++++++++++
 tb/tb_cr_kme_stall_fifo_p.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cr_kme_stall_fifo_p.sv
// ---------------------------------------------------------------------------
// cr_kme_stall_fifo_p
//
// Parametrised synchronous FIFO for KME datapath channels. Sits between a
// producer stage (valid/stall) and a consumer stage (valid/ack). Owns its own
// storage array and pointers. Extends the fixed 34-bit/4-deep stall FIFO with
// a programmable stall threshold, a stall override, a synchronous clear and
// occupancy outputs.
//
// Optional feature macro: CR_KME_STALL_FIFO_OUT_REG_EN
//   When defined, a one-entry registered output stage follows the array.
//   fifo_out/fifo_out_valid then come from flops, total capacity becomes
//   DEPTH+1 and the write-to-output latency from empty becomes 2 cycles.
//
// Ports:
//   clk                     clock, all state on rising edge
//   rst_n                   asynchronous active-low reset
//   fifo_in                 write data
//   fifo_in_valid           write request
//   fifo_in_stall_override  forces fifo_in_stall low
//   fifo_clear              synchronous flush (priority over read/write)
//   fifo_in_stall           back-pressure to producer (advisory)
//   fifo_out                head-of-queue data
//   fifo_out_valid          head entry valid
//   fifo_out_ack            consumer pops head
//   fifo_used_slots         entries held
//   fifo_free_slots         capacity - used
//   fifo_overflow           one-cycle pulse: write attempted while full
//   fifo_underflow          one-cycle pulse: ack while nothing valid
// ---------------------------------------------------------------------------
module cr_kme_stall_fifo_p #(
  parameter int DATA_W       = 34,
  parameter int DEPTH        = 4,
  parameter int STALL_THRESH = 0,
`ifdef CR_KME_STALL_FIFO_OUT_REG_EN
  parameter int CNT_W        = $clog2(DEPTH + 2)
`else
  parameter int CNT_W        = $clog2(DEPTH + 1)
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] fifo_in,
  input  logic              fifo_in_valid,
  input  logic              fifo_in_stall_override,
  input  logic              fifo_clear,
  output logic              fifo_in_stall,
  output logic [DATA_W-1:0] fifo_out,
  output logic              fifo_out_valid,
  input  logic              fifo_out_ack,
  output logic [CNT_W-1:0]  fifo_used_slots,
  output logic [CNT_W-1:0]  fifo_free_slots,
  output logic              fifo_overflow,
  output logic              fifo_underflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef CR_KME_STALL_FIFO_OUT_REG_EN
  localparam int CAP = DEPTH + 1;
`else
  localparam int CAP = DEPTH;
`endif
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CAP_C    = CNT_W'(CAP);
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(STALL_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  arr_cnt;     // entries held in the array only
  logic [CNT_W-1:0]  used;        // total entries held
  logic [CNT_W-1:0]  free;
  logic              full;
  logic              ren;
  logic              wen_ok;
  logic              arr_wr;
  logic              arr_rd;
  logic              ovf_q;
  logic              udf_q;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign full   = (used == CAP_C);
  assign free   = CAP_C - used;
  assign ren    = fifo_out_valid & fifo_out_ack;
  assign wen_ok = fifo_in_valid & (~full | ren);
  assign arr_wr = wen_ok;

`ifdef CR_KME_STALL_FIFO_OUT_REG_EN
  logic [DATA_W-1:0] out_q;
  logic              out_v;

  // Array feeds the output register whenever that register is empty or is
  // being popped this cycle, so a popped head is replaced on the same edge.
  // While out_v is low the array holds at most one entry, so a write to a
  // full array always coincides with an array read.
  assign arr_rd = (arr_cnt != '0) & (~out_v | ren);
  assign used   = arr_cnt + CNT_W'(out_v);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v <= 1'b0;
    end else if (fifo_clear) begin
      out_v <= 1'b0;
    end else if (~out_v | ren) begin
      out_v <= (arr_cnt != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (arr_rd && !fifo_clear) begin
      out_q <= mem[rd_ptr];
    end
  end

  assign fifo_out       = out_q;
  assign fifo_out_valid = out_v;
`else
  assign arr_rd         = ren;
  assign used           = arr_cnt;
  assign fifo_out       = mem[rd_ptr];
  assign fifo_out_valid = (used != '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      arr_cnt <= '0;
    end else if (fifo_clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      arr_cnt <= '0;
    end else begin
      if (arr_wr) wr_ptr <= ptr_inc(wr_ptr);
      if (arr_rd) rd_ptr <= ptr_inc(rd_ptr);
      case ({arr_wr, arr_rd})
        2'b10:   arr_cnt <= arr_cnt + CNT_W'(1);
        2'b01:   arr_cnt <= arr_cnt - CNT_W'(1);
        default: arr_cnt <= arr_cnt;
      endcase
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (arr_wr && !fifo_clear) begin
      mem[wr_ptr] <= fifo_in;
    end
  end

  // Error pulses report the cycle's events even when a clear is also present.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= fifo_in_valid & full & ~ren;
      udf_q <= fifo_out_ack & ~fifo_out_valid;
    end
  end

  assign fifo_in_stall   = (free <= THRESH_C) & ~fifo_in_stall_override;
  assign fifo_used_slots = used;
  assign fifo_free_slots = free;
  assign fifo_overflow   = ovf_q;
  assign fifo_underflow  = udf_q;

endmodule

// File: tb/tb_cr_kme_stall_fifo_p.sv
// ---------------------------------------------------------------------------
// tb_cr_kme_stall_fifo_p
//
// Three FIFO instances (DEPTH/THRESH = 4/0, 3/1, 4/3) receive the same
// producer/consumer stimulus. Each is compared every cycle against a queue
// model that applies the FIFO rules directly: accept while not full (or when
// the head is popped in the same cycle), pop only a valid head, clear wins.
// ---------------------------------------------------------------------------
module tb_cr_kme_stall_fifo_p;

  localparam int DW = 34;
  localparam int NI = 3;
  localparam int DEP [NI] = '{4, 3, 4};
  localparam int THR [NI] = '{0, 1, 3};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          ack = 1'b0;
  logic          clr = 1'b0;
  logic          ovr = 1'b0;

  logic [DW-1:0] o_out   [NI];
  logic          o_val   [NI];
  logic          o_stall [NI];
  logic          o_ov    [NI];
  logic          o_uf    [NI];
  logic [2:0]    used0, free0, used2, free2;
  logic [1:0]    used1, free1;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [DW-1:0] mq [NI][$];
  logic          e_ov [NI];
  logic          e_uf [NI];

  always #5 clk = ~clk;

  cr_kme_stall_fifo_p #(.DATA_W(DW), .DEPTH(4), .STALL_THRESH(0)) u0 (
    .clk(clk), .rst_n(rst_n), .fifo_in(in_data), .fifo_in_valid(in_valid),
    .fifo_in_stall_override(ovr), .fifo_clear(clr), .fifo_in_stall(o_stall[0]),
    .fifo_out(o_out[0]), .fifo_out_valid(o_val[0]), .fifo_out_ack(ack),
    .fifo_used_slots(used0), .fifo_free_slots(free0),
    .fifo_overflow(o_ov[0]), .fifo_underflow(o_uf[0]));

  cr_kme_stall_fifo_p #(.DATA_W(DW), .DEPTH(3), .STALL_THRESH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .fifo_in(in_data), .fifo_in_valid(in_valid),
    .fifo_in_stall_override(ovr), .fifo_clear(clr), .fifo_in_stall(o_stall[1]),
    .fifo_out(o_out[1]), .fifo_out_valid(o_val[1]), .fifo_out_ack(ack),
    .fifo_used_slots(used1), .fifo_free_slots(free1),
    .fifo_overflow(o_ov[1]), .fifo_underflow(o_uf[1]));

  cr_kme_stall_fifo_p #(.DATA_W(DW), .DEPTH(4), .STALL_THRESH(3)) u2 (
    .clk(clk), .rst_n(rst_n), .fifo_in(in_data), .fifo_in_valid(in_valid),
    .fifo_in_stall_override(ovr), .fifo_clear(clr), .fifo_in_stall(o_stall[2]),
    .fifo_out(o_out[2]), .fifo_out_valid(o_val[2]), .fifo_out_ack(ack),
    .fifo_used_slots(used2), .fifo_free_slots(free2),
    .fifo_overflow(o_ov[2]), .fifo_underflow(o_uf[2]));

  function automatic int get_used(input int k);
    case (k)
      0:       return int'(used0);
      1:       return int'(used1);
      default: return int'(used2);
    endcase
  endfunction

  function automatic int get_free(input int k);
    case (k)
      0:       return int'(free0);
      1:       return int'(free1);
      default: return int'(free2);
    endcase
  endfunction

  function automatic logic exp_stall(input int k);
    return ((DEP[k] - mq[k].size()) <= THR[k]) && !ovr;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      int n;
      n = mq[k].size();
      chk($sformatf("u%0d_used", k), 64'(get_used(k)), 64'(n));
      chk($sformatf("u%0d_free", k), 64'(get_free(k)), 64'(DEP[k] - n));
      chk($sformatf("u%0d_valid", k), 64'(o_val[k]), 64'(n != 0));
      if (n != 0) chk($sformatf("u%0d_out", k), 64'(o_out[k]), 64'(mq[k][0]));
      chk($sformatf("u%0d_stall", k), 64'(o_stall[k]), 64'(exp_stall(k)));
      chk($sformatf("u%0d_ovf", k), 64'(o_ov[k]), 64'(e_ov[k]));
      chk($sformatf("u%0d_udf", k), 64'(o_uf[k]), 64'(e_uf[k]));
    end
  endtask

  // One clock cycle: drive, check combinational stall, advance the model,
  // take the edge, check everything.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic a,
                      input logic c, input logic o);
    in_valid = v; in_data = d; ack = a; clr = c; ovr = o;
    #1;
    for (int k = 0; k < NI; k++) begin
      int  n;
      logic vld, rd, fl, wr;
      chk($sformatf("u%0d_stall_comb", k), 64'(o_stall[k]), 64'(exp_stall(k)));
      n   = mq[k].size();
      vld = (n != 0);
      rd  = vld & a;
      fl  = (n == DEP[k]);
      wr  = v & (!fl | rd);
      e_ov[k] = v & fl & !rd;
      e_uf[k] = a & !vld;
      if (c) mq[k].delete();
      else begin
        if (rd) void'(mq[k].pop_front());
        if (wr) mq[k].push_back(d);
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Asynchronous reset applied between clock edges.
  task automatic do_reset();
    in_valid = 1'b0; ack = 1'b0; clr = 1'b0; ovr = 1'b0;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      mq[k].delete();
      e_ov[k] = 1'b0;
      e_uf[k] = 1'b0;
    end
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all();
  endtask

  initial begin
    logic [DW-1:0] rd;

    // Reset state
    do_reset();

    // Fill with 1..4, no ack; stall on u0 rises after the 4th edge
    for (int i = 1; i <= 4; i++) step(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);

    // Write into a full FIFO without ack: overflow, data dropped
    step(1'b1, DW'(5), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Empty ack: underflow
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Full plus simultaneous write and ack
    for (int i = 1; i <= 4; i++) step(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, DW'(5), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Streaming with continuous ack (wraps the 3-deep pointers)
    for (int i = 0; i < 10; i++) step(1'b1, DW'(32'h100 + i), 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    // Acks held off: stall on u1 once two entries are held
    for (int i = 0; i < 4; i++) step(1'b1, DW'(32'h200 + i), 1'b0, 1'b0, 1'b0);

    // Clear, two entries, override, then clear with a concurrent write
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b1, DW'(32'h301), 1'b0, 1'b0, 1'b0);
    step(1'b1, DW'(32'h302), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b1, DW'(32'h303), 1'b0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Clear and ack in an empty cycle together with an overflowing write
    for (int i = 1; i <= 4; i++) step(1'b1, DW'(32'h400 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, DW'(32'h405), 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);

    // Mid-stream asynchronous reset with three entries held
    for (int i = 1; i <= 3; i++) step(1'b1, DW'(32'h500 + i), 1'b0, 1'b0, 1'b0);
    #2;
    do_reset();

    // Randomized traffic, alternating fill-biased and drain-biased phases
    for (int i = 0; i < 600; i++) begin
      logic v, a, c, o;
      int   ap;
      ap = ((i / 100) % 2 == 0) ? 25 : 75;
      v  = ($urandom_range(0, 99) < 70);
      a  = ($urandom_range(0, 99) < ap);
      c  = ($urandom_range(0, 39) == 0);
      o  = ($urandom_range(0, 4) == 0);
      rd = DW'({$urandom(), $urandom()});
      step(v, rd, a, c, o);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
